// File: rtl/divisor_pkg.sv
// Shared constants and FSM encoding for the sequential restoring divider.
package divisor_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/restador_4.sv
// Combinational W+1-bit subtract-with-borrow for one restoring division step.
module restador_4 #(
  parameter int W = 4
) (
  input  logic [W:0]   min_i,
  input  logic [W-1:0] sub_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W:0] full;

  assign full   = min_i - {1'b0, sub_i};
  assign diff_o = full[W-1:0];
  // The partial remainder stays below the divisor, so min_i < 2*sub_i and the
  // difference MSB is the borrow; a zero divisor can never borrow.
  assign borrow_o = full[W] & (|sub_i);

endmodule

// File: rtl/divisor_seq.sv
// Sequential restoring divider, one quotient bit per RUN cycle, MSB first.
// Define DIV_ZERO_EN to add the err port and a direct IDLE->DONE path for B=0.
module divisor_seq
  import divisor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
`ifdef DIV_ZERO_EN
  output logic             done,
  output logic             err
`else
  output logic             done
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, rem_q, quo_q;
  logic [WIDTH-1:0] q_q, r_q;
  logic             busy_q, done_q;
`ifdef DIV_ZERO_EN
  logic             err_q;
`endif

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   quo_sh;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_d, quo_d;

  assign rem_sh = {rem_q, a_q[WIDTH-1]};

  restador_4 #(.W(WIDTH)) u_sub (
    .min_i   (rem_sh),
    .sub_i   (b_q),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  always_comb begin
    rem_d  = borrow ? rem_sh[WIDTH-1:0] : diff;
    quo_sh = {quo_q, ~borrow};
    quo_d  = quo_sh[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
`ifdef DIV_ZERO_EN
            err_q <= 1'b0;
            if (B == '0) begin
              q_q     <= '1;
              r_q     <= A;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else
`endif
            begin
              a_q     <= A;
              b_q     <= B;
              cnt_q   <= CW'(WIDTH - 1);
              rem_q   <= '0;
              quo_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          a_q   <= a_q << 1;
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            q_q     <= quo_d;
            r_q     <= rem_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef DIV_ZERO_EN
  assign err  = err_q;
`endif

endmodule

// File: tb/tb_divisor_seq.sv
// Self-checking bench for divisor_seq against a plain-arithmetic division model.
module tb_divisor_seq;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Q, R;
  logic         busy, done;
`ifdef DIV_ZERO_EN
  logic         err;
`endif

  divisor_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .R    (R),
    .busy (busy),
`ifdef DIV_ZERO_EN
    .done (done),
    .err  (err)
`else
    .done (done)
`endif
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string ctx = "";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s [%s] got %0d expected %0d", tag, ctx, obs, exp);
    end
  endtask

  // Issues one division; optionally re-pulses start with other operands
  // at RUN cycle inj (negative = never) to confirm it is ignored.
  task automatic run_div(input int a, input int b, input int inj);
    int lat, nbusy, eq, er, elat;
    eq   = (b == 0) ? MAXV : a / b;
    er   = (b == 0) ? a : a % b;
    elat = W;
`ifdef DIV_ZERO_EN
    if (b == 0) elat = 0;
`endif
    ctx   = $sformatf("%0d/%0d", a, b);
    A     = W'(a);
    B     = W'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 3 * W) begin
      if (busy) nbusy++;
      if (lat == inj) begin
        start = 1'b1;
        A     = W'(2);
        B     = W'(1);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, elat);
    chk("busy_cycles", nbusy, elat);
    chk("done", done, 1);
    chk("busy_in_done", busy, 0);
    chk("Q", Q, eq);
    chk("R", R, er);
    if (b != 0) begin
      chk("identity", Q * b + R, a);
      chk("r_lt_b", R < b, 1);
    end
`ifdef DIV_ZERO_EN
    chk("err", err, (b == 0) ? 1 : 0);
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("hold_Q", Q, eq);
    chk("hold_R", R, er);
  endtask

  initial begin
    ctx   = "reset";
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Q", Q, 0);
    chk("rst_R", R, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef DIV_ZERO_EN
    chk("rst_err", err, 0);
`endif
    rst_n = 1'b1;

    run_div(13, 3, -1);
    run_div(15, 15, -1);
    run_div(5, 7, -1);
    run_div(9, 0, -1);
    run_div(13, 3, 1);

    // Reset lands on the second RUN cycle of 13/3.
    ctx   = "mid_run_reset";
    A     = W'(13);
    B     = W'(3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_Q", Q, 0);
    chk("abort_R", R, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    run_div(6, 2, -1);

    for (int a = 0; a <= MAXV; a++)
      for (int b = 0; b <= MAXV; b++)
        run_div(a, b, -1);

    for (int i = 0; i < 40; i++)
      run_div(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
